// File: rtl/pe_group_scheduler.sv
// Nios II multi-cycle custom-instruction front end that stages operands and round-robins jobs onto NUM_PE PE lanes.
// Optional read/issue wait watchdog: define PE_SCHED_TIMEOUT_EN.

module pe_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic              retire,
    input  logic              pe_done,
    input  logic [DATA_W-1:0] pe_result,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    typedef enum logic [1:0] {FREE, BUSY, VALID} lane_state_t;
    lane_state_t st;

    // Capture is not clk_en gated: a PE completion must never be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= FREE;
            data <= '0;
        end else if (clear) begin
            st <= FREE;
        end else if (issue) begin
            st <= BUSY;
        end else if (retire) begin
            st <= FREE;
        end else if (pe_done && st == BUSY) begin
            st   <= VALID;
            data <= pe_result;
        end
    end

    assign busy  = (st == BUSY);
    assign valid = (st == VALID);
endmodule

module pe_group_scheduler #(
    parameter int NUM_PE  = 4,
    parameter int DATA_W  = 32,
    parameter int LANE_W  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     start,
    input  logic [2:0]               n,
    input  logic [DATA_W-1:0]        dataa,
    output logic [DATA_W-1:0]        result,
    output logic                     done,
    output logic                     pe_issue_valid,
    output logic [LANE_W-1:0]        pe_issue_lane,
    output logic [DATA_W-1:0]        pe_op_a,
    output logic [DATA_W-1:0]        pe_op_b,
    output logic [DATA_W-1:0]        pe_op_c,
    output logic                     pe_flush,
    input  logic [NUM_PE-1:0]        pe_done,
    input  logic [NUM_PE*DATA_W-1:0] pe_result
);
    typedef enum logic [1:0] {IDLE, ISSUE_WAIT, READ_WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] a_q, b_q, c_q, resp_q, resp_nx, op_c_src, status;
    logic [LANE_W-1:0] rr_q, rr_nx, rd_lane_q, rd_lane_nx, sel_lane, pick;
    logic              err_q, err_set, found;
    logic              do_load_a, do_load_b, do_load_c, do_issue, do_flush, do_retire;
    logic              sel_ready, sel_busy, lane_clear;
    logic [DATA_W-1:0] sel_data;
    logic [NUM_PE-1:0] busy_map, valid_map, free_map, issue_vec, retire_vec;
    logic [NUM_PE-1:0][DATA_W-1:0] lane_data;
`ifdef PE_SCHED_TIMEOUT_EN
    logic [7:0]        tmo_q;
`endif

    assign free_map   = ~busy_map & ~valid_map;
    assign lane_clear = do_flush | pe_flush;
    assign sel_lane   = (state == IDLE) ? dataa[LANE_W-1:0] : rd_lane_q;
    assign op_c_src   = (state == IDLE) ? dataa : c_q;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        pe_lane #(.DATA_W(DATA_W)) u_lane (
            .clk(clk), .rst(reset), .clear(lane_clear),
            .issue(issue_vec[i]), .retire(retire_vec[i]),
            .pe_done(pe_done[i]), .pe_result(pe_result[i*DATA_W +: DATA_W]),
            .busy(busy_map[i]), .valid(valid_map[i]), .data(lane_data[i])
        );
    end

    // Round-robin search: smaller offsets from rr_q are visited last so they win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_PE-1; k >= 0; k--)
            for (int i = 0; i < NUM_PE; i++)
                if (i == (int'(rr_q) + k) % NUM_PE && free_map[i]) begin
                    found = 1'b1;
                    pick  = LANE_W'(i);
                end
        rr_nx = (int'(pick) == NUM_PE-1) ? '0 : pick + 1'b1;
    end

    // A BUSY lane completing this very cycle counts as ready (bypass from pe_result).
    always_comb begin
        sel_ready = 1'b0;
        sel_busy  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PE; i++)
            if (sel_lane == LANE_W'(i)) begin
                sel_ready = valid_map[i] | (busy_map[i] & pe_done[i]);
                sel_busy  = busy_map[i];
                sel_data  = valid_map[i] ? lane_data[i] : pe_result[i*DATA_W +: DATA_W];
            end
        status = '0;
        status[NUM_PE-1:0]        = busy_map;
        status[2*NUM_PE-1:NUM_PE] = valid_map;
        status[DATA_W-1]          = err_q;
    end

    always_comb begin
        state_nx   = state;
        resp_nx    = resp_q;
        rd_lane_nx = rd_lane_q;
        do_load_a  = 1'b0;
        do_load_b  = 1'b0;
        do_load_c  = 1'b0;
        do_issue   = 1'b0;
        do_flush   = 1'b0;
        do_retire  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: if (clk_en && start) begin
                state_nx = RESP;
                resp_nx  = '0;
                case (n)
                    3'd0: do_flush  = 1'b1;
                    3'd1: do_load_a = 1'b1;
                    3'd2: do_load_b = 1'b1;
                    3'd3: begin
                        do_load_c = 1'b1;
                        if (found) begin
                            do_issue = 1'b1;
                            resp_nx  = DATA_W'(pick);
                        end else begin
                            state_nx = ISSUE_WAIT;
                        end
                    end
                    3'd4: begin
                        rd_lane_nx = sel_lane;
                        if (sel_ready) begin
                            do_retire = 1'b1;
                            resp_nx   = sel_data;
                        end else if (sel_busy) begin
                            state_nx = READ_WAIT;
                        end
                    end
                    3'd5:    resp_nx = status;
                    default: resp_nx = '0;
                endcase
            end
            ISSUE_WAIT: if (clk_en) begin
                if (found) begin
                    do_issue = 1'b1;
                    resp_nx  = DATA_W'(pick);
                    state_nx = RESP;
                end
`ifdef PE_SCHED_TIMEOUT_EN
                else if (tmo_q == 8'(TIMEOUT-1)) begin
                    resp_nx  = '1;
                    err_set  = 1'b1;
                    state_nx = RESP;
                end
`endif
            end
            READ_WAIT: if (clk_en) begin
                if (sel_ready) begin
                    do_retire = 1'b1;
                    resp_nx   = sel_data;
                    state_nx  = RESP;
                end
`ifdef PE_SCHED_TIMEOUT_EN
                else if (tmo_q == 8'(TIMEOUT-1)) begin
                    resp_nx  = '1;
                    err_set  = 1'b1;
                    state_nx = RESP;
                end
`endif
            end
            RESP: if (clk_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            issue_vec[i]  = do_issue  && (pick == LANE_W'(i));
            retire_vec[i] = do_retire && (sel_lane == LANE_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            resp_q         <= '0;
            rd_lane_q      <= '0;
            rr_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            err_q          <= 1'b0;
            pe_issue_valid <= 1'b0;
            pe_issue_lane  <= '0;
            pe_op_a        <= '0;
            pe_op_b        <= '0;
            pe_op_c        <= '0;
            pe_flush       <= 1'b0;
        end else begin
            pe_issue_valid <= do_issue;
            pe_flush       <= do_flush;
            if (clk_en) begin
                state     <= state_nx;
                resp_q    <= resp_nx;
                rd_lane_q <= rd_lane_nx;
            end
            if (do_load_a) a_q <= dataa;
            if (do_load_b) b_q <= dataa;
            if (do_load_c) c_q <= dataa;
            if (do_issue) begin
                pe_issue_lane <= pick;
                pe_op_a       <= a_q;
                pe_op_b       <= b_q;
                pe_op_c       <= op_c_src;
                rr_q          <= rr_nx;
            end
            if (err_set) err_q <= 1'b1;
            if (do_flush) begin
                a_q   <= '0;
                b_q   <= '0;
                c_q   <= '0;
                rr_q  <= '0;
                err_q <= 1'b0;
            end
        end
    end

`ifdef PE_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_q <= '0;
        else if (clk_en)
            tmo_q <= (state == ISSUE_WAIT || state == READ_WAIT) ? tmo_q + 8'd1 : 8'd0;
    end
`endif

    assign done   = (state == RESP) && clk_en;
    assign result = resp_q;
endmodule

// File: tb/tb_pe_group_scheduler.sv
// Directed self-checking bench for pe_group_scheduler (NUM_PE=4, TIMEOUT=10).
module tb_pe_group_scheduler;
    localparam int NUM_PE = 4;
    localparam int DW     = 32;

    logic              clk = 1'b0;
    logic              reset, clk_en, start;
    logic [2:0]        n;
    logic [DW-1:0]     dataa, result, pe_op_a, pe_op_b, pe_op_c;
    logic              done, pe_issue_valid, pe_flush;
    logic [1:0]        pe_issue_lane;
    logic [NUM_PE-1:0] pe_done;
    logic [NUM_PE*DW-1:0] pe_result;

    int n_cmp = 0;
    int n_bad = 0;

    logic          s_done, s_iv, s_flush;
    logic [DW-1:0] s_res;
    logic [1:0]    s_lane;

    pe_group_scheduler #(.NUM_PE(NUM_PE), .DATA_W(DW), .LANE_W(2), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n), .dataa(dataa),
        .result(result), .done(done), .pe_issue_valid(pe_issue_valid),
        .pe_issue_lane(pe_issue_lane), .pe_op_a(pe_op_a), .pe_op_b(pe_op_b),
        .pe_op_c(pe_op_c), .pe_flush(pe_flush), .pe_done(pe_done), .pe_result(pe_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in cycle T, sample outputs in T+1, then step back to IDLE.
    task automatic instr(input logic [2:0] op, input logic [DW-1:0] d);
        start = 1'b1; n = op; dataa = d;
        tick();
        start = 1'b0;
        s_done = done; s_res = result; s_iv = pe_issue_valid;
        s_lane = pe_issue_lane; s_flush = pe_flush;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0;
        pe_done = '0; pe_result = '0; reset = 1'b1;
        tick(); tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_issue", {31'd0, pe_issue_valid}, 32'd0);
        chk("rst_opa", pe_op_a, 32'd0);
        reset = 1'b0;
        tick();

        // operand staging and first issue
        instr(3'd1, 32'h40800000);
        chk("ldA_done", {31'd0, s_done}, 32'd1);
        chk("ldA_res", s_res, 32'd0);
        chk("done_1cyc", {31'd0, done}, 32'd0);
        instr(3'd2, 32'h41A00000);
        chk("ldB_done", {31'd0, s_done}, 32'd1);
        instr(3'd3, 32'h41A00000);
        chk("iss_done", {31'd0, s_done}, 32'd1);
        chk("iss_valid", {31'd0, s_iv}, 32'd1);
        chk("iss_lane", {30'd0, s_lane}, 32'd0);
        chk("iss_res", s_res, 32'd0);
        chk("op_a", pe_op_a, 32'h40800000);
        chk("op_b", pe_op_b, 32'h41A00000);
        chk("op_c", pe_op_c, 32'h41A00000);
        chk("iss_pulse", {31'd0, pe_issue_valid}, 32'd0);

        // fill all lanes after a flush, then stall the fifth job
        instr(3'd0, 32'd0);
        chk("flush0", {31'd0, s_flush}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            instr(3'd3, 32'h100 + j);
            chk($sformatf("fill%0d_lane", j), {30'd0, s_lane}, j);
            chk($sformatf("fill%0d_res", j), s_res, j);
        end
        start = 1'b1; n = 3'd3; dataa = 32'h200;
        tick(); start = 1'b0;
        chk("stall_done0", {31'd0, done}, 32'd0);
        pe_done = 4'b0010; pe_result[1*DW +: DW] = 32'h42C80000;
        tick(); pe_done = '0;
        chk("stall_done1", {31'd0, done}, 32'd0);
        tick();
        chk("stall_issue", {31'd0, pe_issue_valid}, 32'd0);
        // a blocking instruction is in flight: new starts are ignored
        start = 1'b1; n = 3'd4; dataa = 32'd1;
        tick(); start = 1'b0;
        tick();
        chk("stall_ignore", {31'd0, done}, 32'd0);
        reset = 1'b1; #2;
        chk("midrst_done", {31'd0, done}, 32'd0);
        tick(); reset = 1'b0; tick();

        // same scenario with the read allowed: VALID lane 1 then re-issue lands on lane 1
        for (int j = 0; j < 4; j++) instr(3'd3, 32'h300 + j);
        pe_done = 4'b0010; pe_result[1*DW +: DW] = 32'h42C80000;
        tick(); pe_done = '0;
        instr(3'd3, 32'h400);
        chk("full_nodone", {31'd0, s_done}, 32'd0);
        do_reset();
        for (int j = 0; j < 4; j++) instr(3'd3, 32'h300 + j);
        pe_done = 4'b0010;
        tick(); pe_done = '0;
        instr(3'd4, 32'd1);
        chk("rd1_done", {31'd0, s_done}, 32'd1);
        chk("rd1_res", s_res, 32'h42C80000);
        instr(3'd3, 32'h500);
        chk("reiss_lane", {30'd0, s_lane}, 32'd1);
        chk("reiss_valid", {31'd0, s_iv}, 32'd1);

        // read BUSY lane 2, PE answers 2 cycles into the wait
        start = 1'b1; n = 3'd4; dataa = 32'd2;
        tick(); start = 1'b0;
        chk("rw_t1", {31'd0, done}, 32'd0);
        tick();
        chk("rw_t2", {31'd0, done}, 32'd0);
        tick();
        pe_done = 4'b0100; pe_result[2*DW +: DW] = 32'h43480000;
        chk("rw_t3", {31'd0, done}, 32'd0);
        tick(); pe_done = '0;
        chk("rw_done", {31'd0, done}, 32'd1);
        chk("rw_res", result, 32'h43480000);
        tick();
        instr(3'd5, 32'd0);
        chk("stat_after_rd", s_res, 32'h0000000B);

        // flush with lanes busy; completions in and after the flush cycle are dropped
        start = 1'b1; n = 3'd0;
        tick(); start = 1'b0;
        pe_done = 4'b0001; pe_result[0 +: DW] = 32'hDEADBEEF;
        chk("fl_pulse", {31'd0, pe_flush}, 32'd1);
        chk("fl_done", {31'd0, done}, 32'd1);
        tick(); pe_done = '0;
        chk("fl_1cyc", {31'd0, pe_flush}, 32'd0);
        pe_done = 4'b0001;
        tick(); pe_done = '0;
        instr(3'd5, 32'd0);
        chk("fl_stat", s_res, 32'd0);
        instr(3'd4, 32'd0);
        chk("fl_rd0_done", {31'd0, s_done}, 32'd1);
        chk("fl_rd0_res", s_res, 32'd0);
        instr(3'd6, 32'h12345678);
        chk("n6_res", s_res, 32'd0);
        chk("n6_done", {31'd0, s_done}, 32'd1);

        // clk_en low during a READ_WAIT while the PE completes
        instr(3'd3, 32'h600);
        chk("ce_iss_lane", {30'd0, s_lane}, 32'd0);
        start = 1'b1; n = 3'd4; dataa = 32'd0;
        tick(); start = 1'b0;
        clk_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                pe_done = 4'b0001; pe_result[0 +: DW] = 32'h44000000;
            end
            chk($sformatf("ce_low%0d", c), {31'd0, done}, 32'd0);
            tick(); pe_done = '0;
        end
        clk_en = 1'b1;
        chk("ce_back", {31'd0, done}, 32'd0);
        tick();
        chk("ce_done", {31'd0, done}, 32'd1);
        chk("ce_res", result, 32'h44000000);
        tick();

`ifdef PE_SCHED_TIMEOUT_EN
        instr(3'd3, 32'h700);
        start = 1'b1; n = 3'd4; dataa = 32'd1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("to_wait%0d", c), {31'd0, done}, 32'd0);
            tick();
        end
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_res", result, 32'hFFFFFFFF);
        tick();
        instr(3'd5, 32'd0);
        chk("to_stat", s_res, 32'h80000002);
        instr(3'd0, 32'd0);
        instr(3'd5, 32'd0);
        chk("to_clr", s_res, 32'd0);
`else
        instr(3'd5, 32'd0);
        chk("stat_end", s_res, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
